// File: rtl/transfer_datapath_if.sv
// -----------------------------------------------------------------------------
// transfer_datapath_if
// Memory request/acknowledge bus between the transfer datapath (master) and
// the memory (slave).
//   mem_req    master->slave  request, held until the transfer completes
//   mem_we     master->slave  1 = write, 0 = read
//   mem_addr   master->slave  address, stable while mem_req is high
//   mem_wdata  master->slave  write data, stable while mem_req is high
//   mem_ack    slave->master  transfer done; mem_rdata valid on reads
//   mem_rdata  slave->master  read data
// -----------------------------------------------------------------------------
interface transfer_datapath_if #(
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface : transfer_datapath_if

// File: rtl/transfer_datapath.sv
// -----------------------------------------------------------------------------
// transfer_datapath
// Register-transfer datapath driven by the CPU control FSM. Holds PC, SP, MA,
// MD, IR, A and AP, executes the 4-bit transfer code, and bridges MD to memory
// over a req/ack bus with a timeout.
// Ports:
//   i_clk, i_rstn        clock (rising edge), async active-low reset
//   i_transfer_cmd       transfer code (see cmd_e)
//   i_inc_pc             PC+1 on memory-command completion
//   i_inc_dec_sp         01 SP+1, 10 SP-1 (memory completion or with cmd 0)
//   i_dst_ap             cmds 5/8: 1 selects AP, 0 selects A
//   i_alu_res_to_ap      cmd A: 1 writes AP, 0 writes A
//   i_reset_ir           clear IR (beats cmd 3)
//   i_alu_r, i_in_data   ALU result and input port
//   mem_bus              memory bus (master side)
//   o_busy               combinational hold request to the control FSM
//   o_opcode             IR
//   o_a, o_ap, o_md      ALU operands
//   o_pc, o_sp           program counter, stack pointer
//   o_out_data/_valid    output port register and its 1-cycle write strobe
//   o_mem_err            sticky memory timeout flag
// -----------------------------------------------------------------------------
module transfer_datapath #(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] PC_INIT     = '0,
  parameter logic [DATA_W-1:0] SP_INIT     = '1,
  parameter int                MEM_TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [3:0]          i_transfer_cmd,
  input  logic                i_inc_pc,
  input  logic [1:0]          i_inc_dec_sp,
  input  logic                i_dst_ap,
  input  logic                i_alu_res_to_ap,
  input  logic                i_reset_ir,
  input  logic [DATA_W-1:0]   i_alu_r,
  input  logic [DATA_W-1:0]   i_in_data,
  transfer_datapath_if.master mem_bus,
  output logic                o_busy,
  output logic [7:0]          o_opcode,
  output logic [DATA_W-1:0]   o_a,
  output logic [DATA_W-1:0]   o_ap,
  output logic [DATA_W-1:0]   o_md,
  output logic [DATA_W-1:0]   o_pc,
  output logic [DATA_W-1:0]   o_sp,
  output logic [DATA_W-1:0]   o_out_data,
  output logic                o_out_valid,
  output logic                o_mem_err
);

  typedef enum logic [3:0] {
    CMD_NOP       = 4'h0, CMD_MA_PC    = 4'h1, CMD_MEM_RD   = 4'h2,
    CMD_IR_MD     = 4'h3, CMD_MA_MD    = 4'h4, CMD_ACC_MD   = 4'h5,
    CMD_MA_AP     = 4'h6, CMD_MA_SP    = 4'h7, CMD_MD_ACC   = 4'h8,
    CMD_MEM_WR    = 4'h9, CMD_ACC_ALU  = 4'hA, CMD_PC_MD    = 4'hB,
    CMD_A_IN      = 4'hC, CMD_OUT_A    = 4'hD, CMD_PC_AP    = 4'hE,
    CMD_MD_PC     = 4'hF
  } cmd_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
  // Wait counter counts completed no-ack WAIT cycles; the one that reaches
  // LAST is the final WAIT cycle before the abort.
  localparam logic [7:0]        WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  cmd_e   cmd;
  state_e state_q, state_d;
  logic   issue, mem_done, mem_timeout, busy;

  logic [DATA_W-1:0] pc_q, pc_d, sp_q, sp_d, ma_q, ma_d, md_q, md_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, ap_q, ap_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic              out_valid_q, out_valid_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              mem_err_q, mem_err_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;

  assign cmd = cmd_e'(i_transfer_cmd);

  function automatic logic [DATA_W-1:0] sp_step(input logic [DATA_W-1:0] sp,
                                                input logic [1:0]        step);
    case (step)
      2'b01:   return sp + ONE;
      2'b10:   return sp - ONE;
      default: return sp;
    endcase
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue)                    state_d = ST_WAIT;
      ST_WAIT: if (mem_done || mem_timeout)  state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    issue       = 1'b0;
    mem_done    = 1'b0;
    mem_timeout = 1'b0;
    busy        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issue = (cmd == CMD_MEM_RD) || (cmd == CMD_MEM_WR);
        busy  = issue;
      end
      ST_WAIT: begin
        // An ack on the final WAIT cycle takes priority over the abort.
        mem_done    = mem_bus.mem_ack;
        mem_timeout = !mem_bus.mem_ack && (wait_cnt_q == WAIT_LAST);
        busy        = !mem_done && !mem_timeout;
      end
      default: ;
    endcase
  end

  // ---------------- Datapath next-state ----------------
  always_comb begin
    // NOTE: every _d starts from its _q (strobes from 0), so no path through
    // this block leaves a variable unassigned and no latch is inferred.
    pc_d        = pc_q;
    sp_d        = sp_q;
    ma_d        = ma_q;
    md_d        = md_q;
    ir_d        = ir_q;
    a_d         = a_q;
    ap_d        = ap_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_err_d   = mem_err_q;
    wait_cnt_d  = wait_cnt_q;

    if (state_q == ST_IDLE) begin
      case (cmd)
        CMD_NOP:     sp_d = sp_step(sp_q, i_inc_dec_sp);
        CMD_MA_PC:   ma_d = pc_q;
        CMD_IR_MD:   ir_d = md_q;
        CMD_MA_MD:   ma_d = md_q;
        CMD_ACC_MD:  if (i_dst_ap) ap_d = md_q; else a_d = md_q;
        CMD_MA_AP:   ma_d = ap_q;
        CMD_MA_SP:   ma_d = sp_q;
        CMD_MD_ACC:  md_d = i_dst_ap ? ap_q : a_q;
        CMD_ACC_ALU: if (i_alu_res_to_ap) ap_d = i_alu_r; else a_d = i_alu_r;
        CMD_PC_MD:   pc_d = md_q;
        CMD_A_IN:    a_d  = i_in_data;
        CMD_OUT_A: begin
          out_data_d  = a_q;
          out_valid_d = 1'b1;
        end
        CMD_PC_AP:   pc_d = ap_q;
        CMD_MD_PC:   md_d = pc_q;
        CMD_MEM_RD, CMD_MEM_WR: begin
          mem_req_d   = 1'b1;
          mem_we_d    = (cmd == CMD_MEM_WR);
          mem_addr_d  = ma_q;
          mem_wdata_d = md_q;
          wait_cnt_d  = '0;
        end
        default: ;
      endcase
    end else begin
      // Other commands and steps are ignored while a transfer is in flight.
      if (mem_done) begin
        mem_req_d = 1'b0;
        if (!mem_we_q) md_d = mem_bus.mem_rdata;
        if (i_inc_pc)  pc_d = pc_q + ONE;
        sp_d = sp_step(sp_q, i_inc_dec_sp);
      end else if (mem_timeout) begin
        mem_req_d = 1'b0;
        mem_err_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end

    if (i_reset_ir) ir_d = '0;
  end

  // ---------------- Registers ----------------
  // NOTE: the reset is asynchronous so an in-flight request is dropped the
  // moment i_rstn falls, without waiting for a clock edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q        <= PC_INIT;
      sp_q        <= SP_INIT;
      ma_q        <= '0;
      md_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      ap_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its _d value
      // from before the edge, independent of statement order.
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      ma_q        <= ma_d;
      md_q        <= md_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      ap_q        <= ap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_err_q   <= mem_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // ---------------- Outputs ----------------
  assign o_busy            = busy;
  assign o_opcode          = 8'(ir_q);
  assign o_a               = a_q;
  assign o_ap              = ap_q;
  assign o_md              = md_q;
  assign o_pc              = pc_q;
  assign o_sp              = sp_q;
  assign o_out_data        = out_data_q;
  assign o_out_valid       = out_valid_q;
  assign o_mem_err         = mem_err_q;
  assign mem_bus.mem_req   = mem_req_q;
  assign mem_bus.mem_we    = mem_we_q;
  assign mem_bus.mem_addr  = mem_addr_q;
  assign mem_bus.mem_wdata = mem_wdata_q;

endmodule : transfer_datapath

// File: tb/tb_transfer_datapath.sv
// -----------------------------------------------------------------------------
// tb_transfer_datapath
// Directed bench for transfer_datapath: fetch, pop with SP wrap, store, ack on
// the last allowed WAIT cycle, timeout, ALU/IO transfers and reset mid-WAIT.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_transfer_datapath;

  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] i_transfer_cmd;
  logic       i_inc_pc, i_dst_ap, i_alu_res_to_ap, i_reset_ir;
  logic [1:0] i_inc_dec_sp;
  logic [7:0] i_alu_r, i_in_data;
  logic       o_busy, o_out_valid, o_mem_err;
  logic [7:0] o_opcode, o_a, o_ap, o_md, o_pc, o_sp, o_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  transfer_datapath_if #(.DATA_W(8)) mem_if ();

  transfer_datapath #(
    .DATA_W(8), .PC_INIT(8'h00), .SP_INIT(8'hFF), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .i_transfer_cmd  (i_transfer_cmd),
    .i_inc_pc        (i_inc_pc),
    .i_inc_dec_sp    (i_inc_dec_sp),
    .i_dst_ap        (i_dst_ap),
    .i_alu_res_to_ap (i_alu_res_to_ap),
    .i_reset_ir      (i_reset_ir),
    .i_alu_r         (i_alu_r),
    .i_in_data       (i_in_data),
    .mem_bus         (mem_if),
    .o_busy          (o_busy),
    .o_opcode        (o_opcode),
    .o_a             (o_a),
    .o_ap            (o_ap),
    .o_md            (o_md),
    .o_pc            (o_pc),
    .o_sp            (o_sp),
    .o_out_data      (o_out_data),
    .o_out_valid     (o_out_valid),
    .o_mem_err       (o_mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One register command: presented for one cycle, then back to nop.
  task automatic reg_cmd(input logic [3:0] cmd);
    i_transfer_cmd = cmd;
    tick();
    i_transfer_cmd = 4'h0;
  endtask

  // Memory command held until o_busy drops. ack_at = WAIT cycle index (1 = first
  // WAIT cycle) on which the memory acks, 0 = never. cycles = command duration
  // including the final non-busy cycle. Bus values are captured in WAIT cycle 1.
  task automatic mem_cmd(input logic [3:0] cmd, input logic inc_pc,
                         input logic [1:0] sp_step, input int ack_at,
                         input logic [7:0] rdata, output int cycles,
                         output logic req_w1, output logic we_w1,
                         output logic [7:0] addr_w1, output logic [7:0] wdata_w1);
    logic b;
    cycles = 0; req_w1 = 1'b0; we_w1 = 1'b0; addr_w1 = 8'h00; wdata_w1 = 8'h00;
    i_transfer_cmd = cmd;
    i_inc_pc       = inc_pc;
    i_inc_dec_sp   = sp_step;
    for (int c = 0; c < 300; c++) begin
      mem_if.mem_ack   = (ack_at != 0) && (c == ack_at);
      mem_if.mem_rdata = (c == ack_at) ? rdata : 8'hXX;
      if (c == 1) begin
        req_w1   = mem_if.mem_req;
        we_w1    = mem_if.mem_we;
        addr_w1  = mem_if.mem_addr;
        wdata_w1 = mem_if.mem_wdata;
      end
      #1;
      b = o_busy;
      cycles++;
      @(posedge clk);
      #1;
      if (!b) break;
    end
    i_transfer_cmd   = 4'h0;
    i_inc_pc         = 1'b0;
    i_inc_dec_sp     = 2'b00;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 8'h00;
  endtask

  task automatic test_reset();
    if (o_pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", o_pc); end
    n_checks++;
    if (o_sp !== 8'hFF) begin n_fail++; $display("FAIL reset_sp: got %h expected FF", o_sp); end
    n_checks++;
    if ({o_md, o_a, o_ap, o_opcode, o_out_data} !== 40'h0) begin
      n_fail++; $display("FAIL reset_regs: got md=%h a=%h ap=%h ir=%h out=%h expected all 00",
                         o_md, o_a, o_ap, o_opcode, o_out_data);
    end
    n_checks++;
    if ({mem_if.mem_req, o_mem_err, o_out_valid, o_busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got req=%b err=%b valid=%b busy=%b expected 0",
                         mem_if.mem_req, o_mem_err, o_out_valid, o_busy);
    end
    n_checks++;
  endtask

  task automatic test_fetch();
    int cyc; logic rq, we; logic [7:0] ad, wd;
    reg_cmd(4'h1);
    mem_cmd(4'h2, 1'b1, 2'b00, 3, 8'h19, cyc, rq, we, ad, wd);
    if (cyc !== 4) begin n_fail++; $display("FAIL fetch_cycles: got %0d expected 4", cyc); end
    n_checks++;
    if ({rq, we, ad} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL fetch_bus: got req=%b we=%b addr=%h expected 1 0 00", rq, we, ad);
    end
    n_checks++;
    if (o_md !== 8'h19) begin n_fail++; $display("FAIL fetch_md: got %h expected 19", o_md); end
    n_checks++;
    if (o_pc !== 8'h01) begin n_fail++; $display("FAIL fetch_pc: got %h expected 01", o_pc); end
    n_checks++;
    if (mem_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_drop: got %b expected 0", mem_if.mem_req); end
    n_checks++;
    reg_cmd(4'h3);
    if (o_opcode !== 8'h19) begin n_fail++; $display("FAIL fetch_opcode: got %h expected 19", o_opcode); end
    n_checks++;
  endtask

  task automatic test_pop();
    int cyc; logic rq, we; logic [7:0] ad, wd;
    // Standalone SP-1 with nop: FF -> FE in one cycle.
    i_inc_dec_sp = 2'b10;
    tick();
    i_inc_dec_sp = 2'b00;
    if (o_sp !== 8'hFE) begin n_fail++; $display("FAIL sp_standalone: got %h expected FE", o_sp); end
    n_checks++;
    reg_cmd(4'h7);
    mem_cmd(4'h2, 1'b0, 2'b01, 1, 8'h5A, cyc, rq, we, ad, wd);
    if ({o_md, o_sp} !== {8'h5A, 8'hFF}) begin
      n_fail++; $display("FAIL pop1: got md=%h sp=%h expected 5A FF", o_md, o_sp);
    end
    n_checks++;
    if (ad !== 8'hFE) begin n_fail++; $display("FAIL pop1_addr: got %h expected FE", ad); end
    n_checks++;
    reg_cmd(4'h7);
    mem_cmd(4'h2, 1'b0, 2'b01, 1, 8'hC3, cyc, rq, we, ad, wd);
    if ({o_md, o_sp, ad} !== {8'hC3, 8'h00, 8'hFF}) begin
      n_fail++; $display("FAIL pop2_wrap: got md=%h sp=%h addr=%h expected C3 00 FF", o_md, o_sp, ad);
    end
    n_checks++;
    if (o_pc !== 8'h01) begin n_fail++; $display("FAIL pop_pc_kept: got %h expected 01", o_pc); end
    n_checks++;
  endtask

  task automatic test_store();
    int cyc; logic rq, we; logic [7:0] ad, wd;
    // MA <- 40 via A -> MD -> MA, then MD <- A = 3C.
    i_alu_r = 8'h40; i_alu_res_to_ap = 1'b0;
    reg_cmd(4'hA);
    i_dst_ap = 1'b0;
    reg_cmd(4'h8);
    reg_cmd(4'h4);
    i_alu_r = 8'h3C;
    reg_cmd(4'hA);
    reg_cmd(4'h8);
    mem_cmd(4'h9, 1'b0, 2'b00, 1, 8'hEE, cyc, rq, we, ad, wd);
    if (cyc !== 2) begin n_fail++; $display("FAIL store_cycles: got %0d expected 2", cyc); end
    n_checks++;
    if ({rq, we, ad, wd} !== {1'b1, 1'b1, 8'h40, 8'h3C}) begin
      n_fail++; $display("FAIL store_bus: got req=%b we=%b addr=%h wdata=%h expected 1 1 40 3C", rq, we, ad, wd);
    end
    n_checks++;
    if (o_md !== 8'h3C) begin n_fail++; $display("FAIL store_md_kept: got %h expected 3C", o_md); end
    n_checks++;
  endtask

  task automatic test_ack_at_limit();
    int cyc; logic rq, we; logic [7:0] ad, wd;
    mem_cmd(4'h2, 1'b0, 2'b00, MEM_TIMEOUT, 8'hA5, cyc, rq, we, ad, wd);
    if (cyc !== MEM_TIMEOUT + 1) begin
      n_fail++; $display("FAIL limit_cycles: got %0d expected %0d", cyc, MEM_TIMEOUT + 1);
    end
    n_checks++;
    if ({o_md, o_mem_err} !== {8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL limit_ack_wins: got md=%h err=%b expected A5 0", o_md, o_mem_err);
    end
    n_checks++;
  endtask

  task automatic test_timeout();
    int cyc; logic rq, we; logic [7:0] ad, wd;
    mem_cmd(4'h2, 1'b1, 2'b01, 0, 8'h00, cyc, rq, we, ad, wd);
    if (cyc !== MEM_TIMEOUT + 1) begin
      n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", cyc, MEM_TIMEOUT + 1);
    end
    n_checks++;
    if ({o_mem_err, o_md, o_pc, o_sp} !== {1'b1, 8'hA5, 8'h01, 8'h00}) begin
      n_fail++; $display("FAIL timeout_state: got err=%b md=%h pc=%h sp=%h expected 1 A5 01 00",
                         o_mem_err, o_md, o_pc, o_sp);
    end
    n_checks++;
    // Ack while IDLE is ignored; error stays set.
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'h66;
    #1;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_ack_busy: got %b expected 0", o_busy); end
    n_checks++;
    tick();
    tick();
    mem_if.mem_ack = 1'b0;
    if ({o_mem_err, o_md, mem_if.mem_req} !== {1'b1, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL timeout_sticky: got err=%b md=%h req=%b expected 1 A5 0",
                         o_mem_err, o_md, mem_if.mem_req);
    end
    n_checks++;
  endtask

  task automatic test_alu_io();
    i_alu_r = 8'h77; i_alu_res_to_ap = 1'b1;
    reg_cmd(4'hA);
    i_alu_res_to_ap = 1'b0;
    if ({o_ap, o_a} !== {8'h77, 8'h3C}) begin
      n_fail++; $display("FAIL alu_to_ap: got ap=%h a=%h expected 77 3C", o_ap, o_a);
    end
    n_checks++;
    i_in_data = 8'h12;
    reg_cmd(4'hC);
    reg_cmd(4'hD);
    if ({o_out_data, o_out_valid} !== {8'h12, 1'b1}) begin
      n_fail++; $display("FAIL out_write: got data=%h valid=%b expected 12 1", o_out_data, o_out_valid);
    end
    n_checks++;
    tick();
    if ({o_out_data, o_out_valid} !== {8'h12, 1'b0}) begin
      n_fail++; $display("FAIL out_pulse: got data=%h valid=%b expected 12 0", o_out_data, o_out_valid);
    end
    n_checks++;
    // PC <- AP with i_inc_pc asserted: the write wins.
    i_inc_pc = 1'b1;
    reg_cmd(4'hE);
    i_inc_pc = 1'b0;
    if (o_pc !== 8'h77) begin n_fail++; $display("FAIL pc_from_ap: got %h expected 77", o_pc); end
    n_checks++;
    i_dst_ap = 1'b1;
    reg_cmd(4'h5);
    i_dst_ap = 1'b0;
    if ({o_ap, o_a} !== {8'hA5, 8'h12}) begin
      n_fail++; $display("FAIL ap_from_md: got ap=%h a=%h expected A5 12", o_ap, o_a);
    end
    n_checks++;
    i_reset_ir = 1'b1;
    reg_cmd(4'h3);
    i_reset_ir = 1'b0;
    if (o_opcode !== 8'h00) begin n_fail++; $display("FAIL reset_ir_wins: got %h expected 00", o_opcode); end
    n_checks++;
    reg_cmd(4'hB);
    if (o_pc !== 8'hA5) begin n_fail++; $display("FAIL pc_from_md: got %h expected A5", o_pc); end
    n_checks++;
  endtask

  task automatic test_reset_mid_wait();
    i_transfer_cmd = 4'h2;
    tick();
    tick();
    if (mem_if.mem_req !== 1'b1) begin n_fail++; $display("FAIL midwait_req_on: got %b expected 1", mem_if.mem_req); end
    n_checks++;
    i_transfer_cmd = 4'h0;
    #2 rstn = 1'b0;
    #1;
    if ({mem_if.mem_req, o_pc, o_sp, o_mem_err} !== {1'b0, 8'h00, 8'hFF, 1'b0}) begin
      n_fail++; $display("FAIL midwait_reset: got req=%b pc=%h sp=%h err=%b expected 0 00 FF 0",
                         mem_if.mem_req, o_pc, o_sp, o_mem_err);
    end
    n_checks++;
    tick();
    rstn = 1'b1;
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'hEE;
    tick();
    tick();
    mem_if.mem_ack = 1'b0;
    if ({o_md, mem_if.mem_req, o_busy} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL late_ack_ignored: got md=%h req=%b busy=%b expected 00 0 0",
                         o_md, mem_if.mem_req, o_busy);
    end
    n_checks++;
  endtask

  initial begin
    rstn = 1'b0;
    i_transfer_cmd = 4'h0; i_inc_pc = 1'b0; i_inc_dec_sp = 2'b00;
    i_dst_ap = 1'b0; i_alu_res_to_ap = 1'b0; i_reset_ir = 1'b0;
    i_alu_r = 8'h00; i_in_data = 8'h00;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 8'h00;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    test_reset();
    test_fetch();
    test_pop();
    test_store();
    test_ack_at_limit();
    test_timeout();
    test_alu_io();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_transfer_datapath
